// File: rtl/dot_product_seq.sv
// dot_product_seq
// Sequences an iterative multiplier over a stream of operand pairs. It also
// accumulates the products into an unsigned dot-product sum.
//
// Ports
//   in_clk, in_rst              clock (rising edge) / async active-low reset
//   in_a, in_b, in_valid,
//   in_last, out_ready          upstream operand-pair stream
//   out_mult_a, out_mult_b,
//   out_mult_start              operands and one-cycle start to the multiplier
//   in_mult_finished,
//   in_mult_prod                multiplier done level and product
//   out_sum, out_count, out_ovf accumulated sum, term count (saturating),
//                               sticky overflow
//   out_valid, in_ack           result handshake to the consumer
//
// The multiplier is expected to share in_rst with this block.
module dot_product_seq #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 16,
  parameter int unsigned ACC_BITS = 24,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic [IN_BITS-1:0]  in_a,
  input  logic [IN_BITS-1:0]  in_b,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                out_ready,
  output logic [IN_BITS-1:0]  out_mult_a,
  output logic [IN_BITS-1:0]  out_mult_b,
  output logic                out_mult_start,
  input  logic                in_mult_finished,
  input  logic [OUT_BITS-1:0] in_mult_prod,
  output logic [ACC_BITS-1:0] out_sum,
  output logic [CNT_BITS-1:0] out_count,
  output logic                out_ovf,
  output logic                out_valid,
  input  logic                in_ack
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SETTLE,
    WAIT,
    ACC,
    DONE
  } state_t;

  state_t            state;
  logic              last_r;
  logic [ACC_BITS:0] acc_next;

  // Keep one extra bit so the carry out of the wrapping add can set the overflow flag.
  always_comb begin
    acc_next = {1'b0, out_sum} + {{(ACC_BITS + 1 - OUT_BITS){1'b0}}, in_mult_prod};
  end

  assign out_ready = (state == IDLE);

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state          <= IDLE;
      last_r         <= 1'b0;
      out_mult_a     <= '0;
      out_mult_b     <= '0;
      out_mult_start <= 1'b0;
      out_sum        <= '0;
      out_count      <= '0;
      out_ovf        <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_mult_a     <= in_a;
            out_mult_b     <= in_b;
            last_r         <= in_last;
            out_mult_start <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          out_mult_start <= 1'b0;
          state          <= SETTLE;
        end
        // A finished level left over from the previous product may still be
        // visible here, so it is deliberately not sampled in this state.
        SETTLE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (in_mult_finished) begin
            state <= ACC;
          end
        end
        ACC: begin
          out_sum <= acc_next[ACC_BITS-1:0];
          if (acc_next[ACC_BITS]) begin
            out_ovf <= 1'b1;
          end
          if (out_count != '1) begin
            out_count <= out_count + CNT_BITS'(1);
          end
          if (last_r) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (in_ack) begin
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
module tb_dot_product_seq;

  localparam int unsigned IN_BITS  = 8;
  localparam int unsigned OUT_BITS = 16;
  localparam int unsigned ACC_BITS = 24;
  localparam int unsigned CNT_BITS = 8;

  logic                in_clk = 1'b0;
  logic                in_rst = 1'b0;
  logic [IN_BITS-1:0]  in_a = '0;
  logic [IN_BITS-1:0]  in_b = '0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic                out_ready;
  logic [IN_BITS-1:0]  out_mult_a;
  logic [IN_BITS-1:0]  out_mult_b;
  logic                out_mult_start;
  logic                in_mult_finished;
  logic [OUT_BITS-1:0] in_mult_prod;
  logic [ACC_BITS-1:0] out_sum;
  logic [CNT_BITS-1:0] out_count;
  logic                out_ovf;
  logic                out_valid;
  logic                in_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  int starts = 0;

  dot_product_seq #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .ACC_BITS(ACC_BITS),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .out_ready       (out_ready),
    .out_mult_a      (out_mult_a),
    .out_mult_b      (out_mult_b),
    .out_mult_start  (out_mult_start),
    .in_mult_finished(in_mult_finished),
    .in_mult_prod    (in_mult_prod),
    .out_sum         (out_sum),
    .out_count       (out_count),
    .out_ovf         (out_ovf),
    .out_valid       (out_valid),
    .in_ack          (in_ack)
  );

  always #5 in_clk = ~in_clk;

  // Multiplier model: random 2..5 cycle latency. finished stays high after a
  // product and drops one cycle after the next start, so it is stale while
  // the sequencer is one cycle past start.
  int unsigned         mcnt;
  logic                mkill;
  logic [IN_BITS-1:0]  ma, mb;
  always @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      in_mult_finished <= 1'b0;
      in_mult_prod     <= '0;
      mcnt             <= 0;
      mkill            <= 1'b0;
      ma               <= '0;
      mb               <= '0;
    end else if (out_mult_start) begin
      mcnt  <= $urandom_range(5, 2);
      mkill <= 1'b1;
      ma    <= out_mult_a;
      mb    <= out_mult_b;
    end else begin
      if (mkill) begin
        in_mult_finished <= 1'b0;
        mkill            <= 1'b0;
      end
      if (mcnt != 0) mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        in_mult_finished <= 1'b1;
        in_mult_prod     <= OUT_BITS'(ma) * OUT_BITS'(mb);
      end
    end
  end

  always @(posedge in_clk) if (out_mult_start) starts <= starts + 1;

  int unsigned qa[$];
  int unsigned qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!out_ready && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    if (n >= 200) chk({tag, "_ready_timeout"}, 32'(out_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    if (n >= 200) chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Present a pair (in_valid left high) and step past its acceptance edge.
  task automatic send_pair(input string tag, input int unsigned a, input int unsigned b,
                           input bit last, input bit detail);
    in_a = IN_BITS'(a);
    in_b = IN_BITS'(b);
    in_last = last;
    in_valid = 1'b1;
    wait_ready(tag);
    @(negedge in_clk);
    if (detail) begin
      chk({tag, "_start_next_cycle"}, 32'(out_mult_start), 32'd1);
      chk({tag, "_ready_low_after_accept"}, 32'(out_ready), 32'd0);
      chk({tag, "_mult_a"}, 32'(out_mult_a), a);
      chk({tag, "_mult_b"}, 32'(out_mult_b), b);
    end
  endtask

  // Feed qa/qb as one vector and check the result against plain arithmetic.
  task automatic run_vector(input string tag, input bit do_ack, input bit detail);
    longint unsigned total = 0;
    int s0 = starts;
    int n = qa.size();
    for (int i = 0; i < n; i++) begin
      total += longint'(qa[i]) * longint'(qb[i]);
      send_pair(tag, qa[i], qb[i], (i == n - 1), detail);
    end
    in_valid = 1'b0;
    wait_valid(tag);
    chk({tag, "_sum"}, 32'(out_sum), 32'(total % (64'd1 << ACC_BITS)));
    chk({tag, "_count"}, 32'(out_count), (n > 255) ? 32'd255 : 32'(n));
    chk({tag, "_ovf"}, 32'(out_ovf), (total >= (64'd1 << ACC_BITS)) ? 32'd1 : 32'd0);
    chk({tag, "_starts"}, 32'(starts - s0), 32'(n));
    chk({tag, "_ready_in_done"}, 32'(out_ready), 32'd0);
    if (do_ack) begin
      in_ack = 1'b1;
      @(negedge in_clk);
      in_ack = 1'b0;
      chk({tag, "_valid_after_ack"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_after_ack"}, 32'(out_ready), 32'd1);
      chk({tag, "_sum_cleared"}, 32'(out_sum), 32'd0);
    end
  endtask

  initial begin
    int s0;
    logic [ACC_BITS-1:0] held_sum;
    repeat (3) @(negedge in_clk);
    chk("reset_ready", 32'(out_ready), 32'd1);
    chk("reset_start", 32'(out_mult_start), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(out_sum), 32'd0);
    chk("reset_count", 32'(out_count), 32'd0);
    chk("reset_ovf", 32'(out_ovf), 32'd0);
    chk("reset_mult_a", 32'(out_mult_a), 32'd0);
    in_rst = 1'b1;
    @(negedge in_clk);

    qa = '{123}; qb = '{234};
    run_vector("single", 1'b1, 1'b1);

    qa = '{1, 3, 5}; qb = '{2, 4, 6};
    run_vector("three", 1'b0, 1'b1);
    chk("three_sum_const", 32'(out_sum), 32'd44);
    in_ack = 1'b1; @(negedge in_clk); in_ack = 1'b0;

    // Every op leaves finished high, so the second product must not be replaced by the first.
    qa = '{10, 7}; qb = '{10, 3};
    run_vector("stale", 1'b0, 1'b1);
    chk("stale_sum_const", 32'(out_sum), 32'd121);
    in_ack = 1'b1; @(negedge in_clk); in_ack = 1'b0;

    qa = {}; qb = {};
    for (int i = 0; i < 258; i++) begin qa.push_back(255); qb.push_back(255); end
    run_vector("ovf258", 1'b0, 1'b0);
    chk("ovf258_sum_const", 32'(out_sum), 32'd16776450);
    in_ack = 1'b1; @(negedge in_clk); in_ack = 1'b0;
    qa.push_back(255); qb.push_back(255);
    run_vector("ovf259", 1'b0, 1'b0);
    chk("ovf259_sum_const", 32'(out_sum), 32'd64259);
    chk("ovf259_ovf_const", 32'(out_ovf), 32'd1);
    in_ack = 1'b1; @(negedge in_clk); in_ack = 1'b0;

    // Backpressure: result held while a new pair waits upstream.
    qa = '{20, 30}; qb = '{40, 50};
    run_vector("bp", 1'b0, 1'b0);
    held_sum = out_sum;
    s0 = starts;
    in_a = 8'd2; in_b = 8'd2; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge in_clk);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_sum_held", 32'(out_sum), 32'd2300);
      chk("bp_count_held", 32'(out_count), 32'd2);
      chk("bp_ready_low", 32'(out_ready), 32'd0);
    end
    chk("bp_sum_vs_first", 32'(out_sum), 32'(held_sum));
    in_ack = 1'b1;
    @(negedge in_clk);
    in_ack = 1'b0;
    chk("bp_valid_dropped", 32'(out_valid), 32'd0);
    chk("bp_ready_after_ack", 32'(out_ready), 32'd1);
    chk("bp_no_accept_at_ack", 32'(starts - s0), 32'd0);
    @(negedge in_clk);
    chk("bp_accept_after_ack", 32'(out_mult_start), 32'd1);
    in_valid = 1'b0;
    wait_valid("bp2");
    chk("bp2_sum", 32'(out_sum), 32'd4);
    in_ack = 1'b1; @(negedge in_clk); in_ack = 1'b0;

    // Asynchronous reset while waiting on the multiplier.
    send_pair("rst", 9, 9, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge in_clk);
    wait_ready("rst_first");
    chk("rst_partial_sum", 32'(out_sum), 32'd81);
    send_pair("rst", 4, 4, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge in_clk);
    @(negedge in_clk);
    #2 in_rst = 1'b0;
    #1;
    chk("rst_start", 32'(out_mult_start), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    @(negedge in_clk);
    in_rst = 1'b1;
    @(negedge in_clk);
    qa = '{2}; qb = '{3};
    run_vector("after_rst", 1'b1, 1'b1);

    for (int v = 0; v < 6; v++) begin
      int len = $urandom_range(6, 1);
      qa = {}; qb = {};
      for (int i = 0; i < len; i++) begin
        qa.push_back($urandom_range(255, 0));
        qb.push_back($urandom_range(255, 0));
      end
      run_vector("rand", 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
Sequencer that drives the iterative multiplier's start/finished handshake from a stream of operand pairs and accumulates the products into a dot-product sum. Sits directly upstream of the multiplier, which it feeds operands and start, and also downstream of it, since it consumes the product. Upstream side is a valid/ready stream with a last flag. Downstream side presents the finished sum with a valid/ack handshake.

Parameters:
IN_BITS, 8, operand width; must match the multiplier's IN_BITS.
OUT_BITS, 16, product width; must match the multiplier's OUT_BITS.
ACC_BITS, 24, accumulator width; ACC_BITS >= OUT_BITS.
CNT_BITS, 8, term-counter width.

Ports:
in_clk  input  1  clock; all state changes on rising edge.
in_rst  input  1  reset; asynchronous, active-low.
in_a  input  IN_BITS  operand a of the current pair.
in_b  input  IN_BITS  operand b of the current pair.
in_valid  input  1  operand pair and in_last are valid.
in_last  input  1  marks the final pair of a vector.
out_ready  output  1  sequencer accepts a pair this cycle.
out_mult_a  output  IN_BITS  operand a to the multiplier.
out_mult_b  output  IN_BITS  operand b to the multiplier.
out_mult_start  output  1  one-cycle start pulse to the multiplier.
in_mult_finished  input  1  multiplier done; level signal.
in_mult_prod  input  OUT_BITS  multiplier product.
out_sum  output  ACC_BITS  accumulated sum.
out_count  output  CNT_BITS  number of accumulated terms.
out_ovf  output  1  sticky accumulator-overflow flag.
out_valid  output  1  out_sum, out_count and out_ovf are final.
in_ack  input  1  consumer accepts the result.

Behaviour:
- Reset (in_rst=0, asynchronous) returns the FSM to IDLE and clears all registers.
  - Reset values: out_mult_a=0, out_mult_b=0, out_mult_start=0, accumulator=0, out_count=0, out_ovf=0, out_valid=0.
  - out_ready follows the state (combinational), so it reads 1 during reset.
  - Reset mid-operation abandons the current pair and partial sum.
  - The multiplier must be reset together with this block.
- FSM states: IDLE, START, SETTLE, WAIT, ACC, DONE.
- IDLE: out_ready=1. On in_valid=1, latch in_a→out_mult_a, in_b→out_mult_b and in_last→last_r, then go to START.
- START: out_mult_start=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle. in_mult_finished is ignored here, so a stale finished from the previous operation is never taken as done.
- WAIT: hold operands stable. On in_mult_finished=1, go to ACC.
- ACC: one cycle.
  - Accumulator update: {carry, acc} = acc + zero-extend(in_mult_prod). Unsigned; the sum wraps modulo 2^ACC_BITS.
  - On carry=1, set out_ovf (sticky).
  - out_count += 1, saturating at 2^CNT_BITS-1.
  - If last_r=1 go to DONE, else go to IDLE.
- DONE: out_valid=1 and out_ready=0; out_sum, out_count and out_ovf are held stable.
  - On in_ack=1: clear accumulator, out_count and out_ovf; go to IDLE. out_valid drops the next cycle.
- out_ready=1 only in IDLE. A pair presented in any other state is not accepted and must be held by the producer.
- in_ack outside DONE is ignored.
- Latency: pair accepted at edge t → start high in cycle t+1 → WAIT from t+3 → sum updated one edge after finished is sampled.
  - Total latency per pair = multiplier latency + 4 cycles.
  - out_valid rises the cycle after ACC of the last pair.
- out_sum is visible in every state (it is the accumulator); it is defined as final only while out_valid=1.
- Zero-length vectors are impossible: every vector contains at least the last pair.

Test Plan:
- Single pair: a=123, b=234, last=1 → out_mult_start pulses once; out_valid=1 with out_sum=28782, out_count=1, out_ovf=0; ack → out_valid=0, out_ready=1.
- Three-term vector (1,2),(3,4),(5,6 last), in_valid held continuously → exactly 3 start pulses; out_ready=0 between acceptances; out_sum=44, out_count=3.
- Overflow with ACC_BITS=24, 259 pairs of (255,255) → out_sum=64259, out_count=259 saturates to 255, out_ovf=1. The 258-pair variant → out_sum=16776450, out_ovf=0.
- Stale finished: multiplier model holds finished=1 from the previous op and drops it one cycle after start → the second product, not the first, is accumulated. Vector (10,10),(7,3 last) → out_sum=121.
- Backpressure: in_ack held low for 10 cycles in DONE → out_valid, out_sum and out_count stable; out_ready=0; a new in_valid is not accepted until one cycle after ack.
- Reset mid-WAIT: in_rst=0 asynchronously → out_mult_start=0, out_valid=0, accumulator=0 immediately. After release, a fresh pair (2,3 last) → out_sum=6, out_count=1.
